// File: rtl/uart_tx_if.sv
// ----------------------------------------------------------------------------
// uart_tx_if
//
// Bundle of the signals between the UART transmit engine and its
// surroundings: the read side of the transmit FIFO, the enable input
// and the serial line / status outputs.
//
// Parameter:
//   WIDTH       data bits per FIFO word / per frame
//
// Signals:
//   tx_en       permits starting a new frame (sampled only while idle)
//   fifo_empty  FIFO empty flag
//   fifo_data   FIFO registered read data, valid the cycle after fifo_r_e
//   fifo_r_e    FIFO read enable, one-cycle pulse per frame
//   tx          serial line, idle high
//   busy        high from the FIFO fetch through the last stop bit
//   tx_done     one-cycle pulse after the final stop bit completes
//
// Modports:
//   master      transmit engine side (drives fifo_r_e, tx, busy, tx_done)
//   slave       environment side (drives tx_en, fifo_empty, fifo_data)
//
// Handshake: this is a pull interface, not valid/ready. The engine asserts
// fifo_r_e for exactly one cycle only while fifo_empty is low; the FIFO
// must present the popped word on fifo_data in the following cycle.
// ----------------------------------------------------------------------------
interface uart_tx_if #(
    parameter int WIDTH = 8
);
    logic             tx_en;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_data;
    logic             fifo_r_e;
    logic             tx;
    logic             busy;
    logic             tx_done;

    modport master (
        input  tx_en,
        input  fifo_empty,
        input  fifo_data,
        output fifo_r_e,
        output tx,
        output busy,
        output tx_done
    );

    modport slave (
        output tx_en,
        output fifo_empty,
        output fifo_data,
        input  fifo_r_e,
        input  tx,
        input  busy,
        input  tx_done
    );
endinterface

// File: rtl/uart_tx.sv
// ----------------------------------------------------------------------------
// uart_tx
//
// Serial transmit engine of the 8-bit UART. Pops one word at a time from the
// transmit FIFO's registered read port and serializes it onto tx as a start
// bit, LSB-first data, an optional even-parity bit and one or two stop bits.
// Every serial bit is held for exactly CLKS_PER_BIT clock cycles.
//
// Parameters:
//   WIDTH         data bits per frame (must match the FIFO width)
//   CLKS_PER_BIT  clock cycles per serial bit, >= 2
//   STOP_BITS     number of stop bits, 1 or 2
//
// Ports:
//   clk           single clock, rising edge
//   rst           asynchronous, active-high reset
//   bus           uart_tx_if.master: tx_en, fifo_empty, fifo_data in;
//                 fifo_r_e, tx, busy, tx_done out (all outputs registered)
//   state_dbg     current FSM state, for observation only
//
// Build option:
//   UART_TX_PARITY_EN  when defined, a PARITY state carrying the XOR of all
//                      data bits is inserted between DATA and STOP. When
//                      undefined no parity logic exists at all.
//
// Sequence: IDLE -> FETCH -> LOAD -> START -> DATA -> [PARITY] -> STOP -> IDLE
// The start bit begins two clocks after the start condition is seen in IDLE.
// ----------------------------------------------------------------------------
module uart_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic        clk,
    input  logic        rst,
    uart_tx_if.master   bus,
    output logic [2:0]  state_dbg
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(WIDTH - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_LOAD   = 3'd2;
    localparam logic [2:0] ST_START  = 3'd3;
    localparam logic [2:0] ST_DATA   = 3'd4;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd5;
`endif
    localparam logic [2:0] ST_STOP   = 3'd6;

    logic [2:0]       state_q,    state_d;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [IDX_W-1:0] bit_idx_q,  bit_idx_d;
    logic             stop_cnt_q, stop_cnt_d;
    logic [WIDTH-1:0] shift_q,    shift_d;
    logic             tx_q,       tx_d;
    logic             busy_q,     busy_d;
    logic             fifo_r_e_q, fifo_r_e_d;
    logic             tx_done_q,  tx_done_d;
`ifdef UART_TX_PARITY_EN
    logic             parity_q,   parity_d;
`endif

    // Last cycle of the current serial bit.
    logic bit_end;
    assign bit_end = (baud_cnt_q == CNT_LAST);

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        stop_cnt_d = stop_cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        fifo_r_e_d = 1'b0;
        tx_done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif

        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (bus.tx_en && !bus.fifo_empty) begin
                    fifo_r_e_d = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = ST_FETCH;
                end
            end

            // The FIFO pops on this edge; its word is valid during LOAD.
            ST_FETCH: begin
                state_d = ST_LOAD;
            end

            ST_LOAD: begin
                shift_d    = bus.fifo_data;
`ifdef UART_TX_PARITY_EN
                parity_d   = ^bus.fifo_data;
`endif
                tx_d       = 1'b0;
                baud_cnt_d = '0;
                bit_idx_d  = '0;
                stop_cnt_d = 1'b0;
                state_d    = ST_START;
            end

            // tx is updated one cycle ahead of the bit it belongs to, so the
            // next bit value is loaded on the last cycle of the current one.
            ST_START: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    tx_d       = shift_q[0];
                    shift_d    = shift_q >> 1;
                    state_d    = ST_DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end

            ST_DATA: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    if (bit_idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = parity_q;
                        state_d = ST_PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end

`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    tx_d       = 1'b1;
                    state_d    = ST_STOP;
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
`endif

            // stop_cnt counts whole stop bits; tx stays high throughout.
            ST_STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    baud_cnt_d = '0;
                    if (stop_cnt_q == STOP_LAST) begin
                        stop_cnt_d = 1'b0;
                        tx_done_d  = 1'b1;
                        busy_d     = 1'b0;
                        state_d    = ST_IDLE;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end

            default: begin
                tx_d       = 1'b1;
                busy_d     = 1'b0;
                baud_cnt_d = '0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    // Reset is immediate: a frame in flight is abandoned and its word lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            stop_cnt_q <= 1'b0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            fifo_r_e_q <= 1'b0;
            tx_done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            stop_cnt_q <= stop_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            fifo_r_e_q <= fifo_r_e_d;
            tx_done_q  <= tx_done_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign bus.tx       = tx_q;
    assign bus.busy     = busy_q;
    assign bus.fifo_r_e = fifo_r_e_q;
    assign bus.tx_done  = tx_done_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// ----------------------------------------------------------------------------
// tb_uart_tx
//
// Directed bench for uart_tx. Two instances share clock and reset:
//   dut_a  CLKS_PER_BIT=4, STOP_BITS=1
//   dut_b  CLKS_PER_BIT=4, STOP_BITS=2
// Each has a small FIFO model with a registered read port. Expected serial
// bits are queued per frame and compared against tx every clock.
// ----------------------------------------------------------------------------
module tb_uart_tx;

    localparam int CPB = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_if #(.WIDTH(8)) a_if ();
    uart_tx_if #(.WIDTH(8)) b_if ();
    logic [2:0] st_a;
    logic [2:0] st_b;

    uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .bus       (a_if),
        .state_dbg (st_a)
    );

    uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .bus       (b_if),
        .state_dbg (st_b)
    );

    // ---------------- FIFO models ----------------
    logic [7:0] mem_a [16];
    logic [7:0] mem_b [16];
    logic [3:0] wr_a = '0;
    logic [3:0] rd_a = '0;
    logic [3:0] wr_b = '0;
    logic [3:0] rd_b = '0;
    int re_cnt_a = 0;
    int re_cnt_b = 0;

    assign a_if.fifo_empty = (wr_a == rd_a);
    assign b_if.fifo_empty = (wr_b == rd_b);

    always @(posedge clk) begin
        if (a_if.fifo_r_e) begin
            re_cnt_a <= re_cnt_a + 1;
            if (wr_a != rd_a) begin
                a_if.fifo_data <= mem_a[rd_a];
                rd_a <= rd_a + 4'd1;
            end
        end
        if (b_if.fifo_r_e) begin
            re_cnt_b <= re_cnt_b + 1;
            if (wr_b != rd_b) begin
                b_if.fifo_data <= mem_b[rd_b];
                rd_b <= rd_b + 4'd1;
            end
        end
    end

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic get_tx(input int sel);
        return (sel == 0) ? a_if.tx : b_if.tx;
    endfunction
    function automatic logic get_busy(input int sel);
        return (sel == 0) ? a_if.busy : b_if.busy;
    endfunction
    function automatic logic get_re(input int sel);
        return (sel == 0) ? a_if.fifo_r_e : b_if.fifo_r_e;
    endfunction
    function automatic logic get_done(input int sel);
        return (sel == 0) ? a_if.tx_done : b_if.tx_done;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic push_a(input logic [7:0] v);
        mem_a[wr_a] = v;
        wr_a = wr_a + 4'd1;
    endtask

    task automatic push_b(input logic [7:0] v);
        mem_b[wr_b] = v;
        wr_b = wr_b + 4'd1;
    endtask

    // Called at a negedge where the selected DUT sits in IDLE with its start
    // condition true (or in the tx_done cycle of the previous frame). Checks
    // FETCH, LOAD, every cycle of every serial bit and the tx_done cycle.
    task automatic frame_seq(input int sel, input logic [7:0] data, input int nstop, input string tag);
        logic exp_q[$];
        logic e;
        int   b;
        exp_q = {};
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(data[i]);
`ifdef UART_TX_PARITY_EN
        exp_q.push_back(^data);
`endif
        for (int i = 0; i < nstop; i++) exp_q.push_back(1'b1);

        @(negedge clk);
        check_eq({tag, "_fetch_re"},   32'(get_re(sel)),   32'd1);
        check_eq({tag, "_fetch_busy"}, 32'(get_busy(sel)), 32'd1);
        check_eq({tag, "_fetch_tx"},   32'(get_tx(sel)),   32'd1);
        @(negedge clk);
        check_eq({tag, "_load_re"},    32'(get_re(sel)),   32'd0);
        check_eq({tag, "_load_tx"},    32'(get_tx(sel)),   32'd1);

        b = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                check_eq($sformatf("%s_bit%0d_c%0d_tx", tag, b, c), 32'(get_tx(sel)), 32'(e));
            end
            check_eq($sformatf("%s_bit%0d_busy", tag, b), 32'(get_busy(sel)), 32'd1);
            check_eq($sformatf("%s_bit%0d_done", tag, b), 32'(get_done(sel)), 32'd0);
            b = b + 1;
        end

        @(negedge clk);
        check_eq({tag, "_done"},      32'(get_done(sel)), 32'd1);
        check_eq({tag, "_done_busy"}, 32'(get_busy(sel)), 32'd0);
        check_eq({tag, "_done_tx"},   32'(get_tx(sel)),   32'd1);
        check_eq({tag, "_done_re"},   32'(get_re(sel)),   32'd0);
    endtask

    // Watch dut_a for a number of cycles and report any activity.
    task automatic watch_idle_a(input int cycles, input string tag);
        int seen_low;
        int seen_busy;
        int re_before;
        seen_low  = 0;
        seen_busy = 0;
        re_before = re_cnt_a;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (a_if.tx !== 1'b1) seen_low = seen_low + 1;
            if (a_if.busy !== 1'b0) seen_busy = seen_busy + 1;
        end
        check_eq({tag, "_re_pulses"}, 32'(re_cnt_a - re_before), 32'd0);
        check_eq({tag, "_tx_low"},    32'(seen_low),             32'd0);
        check_eq({tag, "_busy"},      32'(seen_busy),            32'd0);
        check_eq({tag, "_state"},     32'(st_a),                 32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "bench timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        a_if.tx_en = 1'b0;
        b_if.tx_en = 1'b0;

        // reset values
        @(negedge clk);
        check_eq("rst_a_tx",   32'(a_if.tx),       32'd1);
        check_eq("rst_a_busy", 32'(a_if.busy),     32'd0);
        check_eq("rst_a_re",   32'(a_if.fifo_r_e), 32'd0);
        check_eq("rst_a_done", 32'(a_if.tx_done),  32'd0);
        check_eq("rst_a_state", 32'(st_a),         32'd0);
        check_eq("rst_b_tx",   32'(b_if.tx),       32'd1);
        check_eq("rst_b_state", 32'(st_b),         32'd0);
        rst = 1'b0;

        // empty FIFO with tx_en high: nothing happens
        a_if.tx_en = 1'b1;
        watch_idle_a(100, "empty");

        // word available but tx_en low: nothing happens
        a_if.tx_en = 1'b0;
        push_a(8'hA5);
        watch_idle_a(20, "disabled");

        // single frame 0xA5
        a_if.tx_en = 1'b1;
        frame_seq(0, 8'hA5, 1, "a5");
        repeat (5) @(negedge clk);
        check_eq("a5_re_total", 32'(re_cnt_a), 32'd1);
        check_eq("a5_idle_tx",  32'(a_if.tx),  32'd1);

        // back-to-back with two stop bits on dut_b
        push_b(8'h55);
        push_b(8'hC3);
        b_if.tx_en = 1'b1;
        frame_seq(1, 8'h55, 2, "b2b_55");
        frame_seq(1, 8'hC3, 2, "b2b_c3");
        repeat (5) @(negedge clk);
        check_eq("b2b_re_total", 32'(re_cnt_b), 32'd2);
        check_eq("b2b_idle_tx",  32'(b_if.tx),  32'd1);

        // parity-relevant words, back-to-back on dut_a
        push_a(8'h07);
        push_a(8'h03);
        frame_seq(0, 8'h07, 1, "w07");
        frame_seq(0, 8'h03, 1, "w03");
        repeat (3) @(negedge clk);
        check_eq("w07_w03_re_total", 32'(re_cnt_a), 32'd3);

        // reset in the middle of data bit 3 of 0xFF
        push_a(8'hFF);
        push_a(8'h3C);
        repeat (20) @(negedge clk);
        check_eq("midrst_pre_busy",  32'(a_if.busy), 32'd1);
        check_eq("midrst_pre_state", 32'(st_a),      32'd4);
        #2 rst = 1'b1;
        #1;
        check_eq("midrst_tx",    32'(a_if.tx),   32'd1);
        check_eq("midrst_busy",  32'(a_if.busy), 32'd0);
        check_eq("midrst_state", 32'(st_a),      32'd0);
        @(negedge clk);
        rst = 1'b0;
        frame_seq(0, 8'h3C, 1, "after_rst");
        repeat (3) @(negedge clk);
        check_eq("midrst_re_total", 32'(re_cnt_a), 32'd5);

        // tx_en dropped during DATA: frame completes, nothing further popped
        push_a(8'h96);
        push_a(8'h11);
        fork
            frame_seq(0, 8'h96, 1, "drop");
            begin
                repeat (10) @(negedge clk);
                a_if.tx_en = 1'b0;
            end
        join
        watch_idle_a(20, "drop_after");
        check_eq("drop_re_total", 32'(re_cnt_a), 32'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
